// File: rtl/fpdiv_pkg.sv
// fpdiv_pkg: shared types and constants for the divider arbiter
package fpdiv_pkg;
    localparam int FLAG_W = 5;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef struct packed {
        logic tmo;
        logic unf;
        logic ovf;
        logic zbz;
        logic dbz;
    } fpdiv_flags_t;
    localparam fpdiv_flags_t FLAG_TMO = fpdiv_flags_t'(5'b10000);
endpackage

// File: rtl/fpdiv_arbiter_rr_arb.sv
// rr_arb: combinational round-robin pick of the first request at or after ptr
module rr_arb #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx
);
    localparam int IW = $clog2(NREQ);
    // Scan from the farthest offset down so the nearest requester wins last
    always_comb begin
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (req[(int'(ptr) + i) % NREQ]) idx = IW'((int'(ptr) + i) % NREQ);
        gnt = (|req) ? NREQ'(1) << idx : '0;
    end
endmodule

// File: rtl/fpdiv_arbiter.sv
// fpdiv_arbiter: shares one external FP divider among NREQ requesters,
// one operation in flight, with a timeout on the divider result.
module fpdiv_arbiter
    import fpdiv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NREQ    = 4,
    parameter int TMO_CYC = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]        rsp_c,
    output logic [FLAG_W-1:0]       rsp_flags,
    output logic                    div_start,
    output logic [WIDTH-1:0]        div_a,
    output logic [WIDTH-1:0]        div_b,
    input  logic                    div_busy,
    input  logic                    div_valid,
    input  logic [WIDTH-1:0]        div_c,
    input  logic                    div_dbz,
    input  logic                    div_zbz,
    input  logic                    div_ovf,
    input  logic                    div_unf
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TMO_CYC) + 1;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d, id_q, id_d, gidx;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    fpdiv_flags_t    flags_q, flags_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt;
    logic            acc, tmo;

    rr_arb #(.NREQ(NREQ)) u_arb (.req(req_valid), .ptr(ptr_q), .gnt(gnt), .idx(gidx));

    assign req_ready = (state_q == IDLE) ? gnt : '0;
    // Busy only rises the cycle after start, so the first WAIT cycle is skipped
    assign acc = div_valid && !div_busy && (cnt_q != '0);
    assign tmo = (cnt_q + 1'b1) == CW'(TMO_CYC - 1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        flags_d = flags_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (|req_valid) begin
                id_d    = gidx;
                a_d     = req_a[int'(gidx)*WIDTH +: WIDTH];
                b_d     = req_b[int'(gidx)*WIDTH +: WIDTH];
                ptr_d   = (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (acc) begin
                    c_d     = div_c;
                    flags_d = '{tmo: 1'b0, unf: div_unf, ovf: div_ovf, zbz: div_zbz, dbz: div_dbz};
                    state_d = RESP;
                end else if (tmo) begin
                    c_d     = '0;
                    flags_d = FLAG_TMO;
                    state_d = RESP;
                end
            end
            RESP: state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign div_start = (state_q == ISSUE);
    assign rsp_id    = id_q;
    assign rsp_c     = c_q;
    assign rsp_flags = flags_q;
    assign div_a     = a_q;
    assign div_b     = b_q;
endmodule

// File: tb/tb_fpdiv_arbiter.sv
// tb_fpdiv_arbiter: table-driven and sequence tests with a response scoreboard
// and a behavioural divider model of configurable latency.
module tb_fpdiv_arbiter;
    localparam int W = 32;
    localparam int N = 4;
    localparam int TMO = 64;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0] req_valid = '0, req_ready;
    logic [N*W-1:0] req_a = '0, req_b = '0;
    logic rsp_valid, rsp_ready = 1'b1, div_start;
    logic [1:0] rsp_id;
    logic [W-1:0] rsp_c, div_a, div_b;
    logic [4:0] rsp_flags;

    logic mv = 1'b0, mb = 1'b0, man_v = 1'b0, m_act = 1'b0;
    int mk = 0, m_lat = 2;
    logic [W-1:0] m_c = '0;
    logic [3:0] m_f = '0;

    fpdiv_arbiter #(.WIDTH(W), .NREQ(N), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_c(rsp_c), .rsp_flags(rsp_flags), .div_start(div_start),
        .div_a(div_a), .div_b(div_b), .div_busy(mb), .div_valid(mv | man_v),
        .div_c(m_c), .div_dbz(m_f[0]), .div_zbz(m_f[1]), .div_ovf(m_f[2]), .div_unf(m_f[3])
    );

    always #5 clk = ~clk;

    // Divider model: busy from the cycle after start, valid L cycles after start; L=0 never answers
    always @(posedge clk) begin
        if (div_start) begin
            m_act <= 1'b1; mk <= 1; mb <= 1'b1; mv <= 1'b0;
        end else if (m_act) begin
            mk <= mk + 1;
            if (mv) begin
                mv <= 1'b0; m_act <= 1'b0;
            end else if (m_lat != 0 && mk + 1 == m_lat) begin
                mv <= 1'b1; mb <= 1'b0;
            end
        end
    end

    typedef struct {
        int id;
        logic [W-1:0] c;
        logic [4:0] f;
        int dly;
    } exp_t;
    exp_t sbq[$];
    int glog[$];

    int errs = 0, checks = 0, cyc = 0, st_cyc = 0, n_start = 0;
    logic rv_prev = 1'b0;
    logic [W-1:0] sa = '0, sb = '0;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic bad(string n);
        checks++;
        errs++;
        $display("FAIL %s", n);
    endtask

    task automatic push_exp(int id, logic [W-1:0] c, logic [4:0] f, int dly);
        exp_t e;
        e.id = id; e.c = c; e.f = f; e.dly = dly;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        int gi;
        cyc++;
        if (div_start) begin
            st_cyc = cyc; n_start++; sa = div_a; sb = div_b;
        end
        if (req_ready != '0) begin
            chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
            gi = 0;
            for (int i = 0; i < N; i++) if (req_ready[i]) gi = i;
            glog.push_back(gi);
        end
        if (rsp_valid && !rv_prev) begin
            if (sbq.size() == 0) bad("unexpected_rsp");
            else chk("rsp_delay", 32'(cyc - st_cyc), 32'(sbq[0].dly));
        end
        if (rsp_valid && rsp_ready && sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            chk("rsp_c", rsp_c, e.c);
            chk("rsp_flags", 32'(rsp_flags), 32'(e.f));
        end
        rv_prev = rsp_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(int p, logic [W-1:0] a, logic [W-1:0] b);
        req_valid[p] = 1'b1;
        req_a[p*W +: W] = a;
        req_b[p*W +: W] = b;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready[p]) begin
                tick();
                req_valid[p] = 1'b0;
                return;
            end
        end
        bad("grant_timeout");
        req_valid[p] = 1'b0;
        tick();
    endtask

    task automatic wait_drain(int max);
        for (int i = 0; i < max && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            bad("drain_timeout");
            sbq.delete();
        end
        tick();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    typedef struct {
        int port;
        logic [W-1:0] a, b, mc;
        logic [3:0] mf;
        int lat;
        logic [W-1:0] ec;
        logic [4:0] ef;
    } vec_t;
    vec_t vecs[8];

    initial begin
        int s0;
        logic [W-1:0] va, vb;
        vecs[0] = '{2, 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 2, 32'h40400000, 5'b00000};
        vecs[1] = '{0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 3, 32'h3EAAAAAB, 5'b00000};
        vecs[2] = '{3, 32'h7F000000, 32'h00800000, 32'h7F800000, 4'b0100, 5, 32'h7F800000, 5'b00100};
        vecs[3] = '{1, 32'h00800000, 32'h7F000000, 32'h00000000, 4'b1000, 4, 32'h00000000, 5'b01000};
        vecs[4] = '{2, 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0010, 2, 32'h7FC00000, 5'b00010};
        vecs[5] = '{0, 32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, TMO - 1, 32'h3F800000, 5'b00000};
        vecs[6] = '{1, 32'h40000000, 32'h3F800000, 32'h40000000, 4'b0000, TMO, 32'h00000000, 5'b10000};
        vecs[7] = '{3, 32'h41200000, 32'h40A00000, 32'h40000000, 4'b0000, 0, 32'h00000000, 5'b10000};

        tick();
        tick();
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_c", rsp_c, 0);
        chk("rst_rsp_flags", 32'(rsp_flags), 0);
        chk("rst_div_start", 32'(div_start), 0);
        chk("rst_div_a", div_a, 0);
        chk("rst_div_b", div_b, 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        tick();
        rst_n = 1'b1;
        tick();

        foreach (vecs[k]) begin
            m_lat = vecs[k].lat; m_c = vecs[k].mc; m_f = vecs[k].mf;
            push_exp(vecs[k].port, vecs[k].ec, vecs[k].ef, vecs[k].ef[4] ? TMO : vecs[k].lat + 1);
            s0 = n_start;
            issue(vecs[k].port, vecs[k].a, vecs[k].b);
            wait_drain(200);
            chk("start_pulses", 32'(n_start - s0), 1);
            chk("div_a_at_start", sa, vecs[k].a);
            chk("div_b_at_start", sb, vecs[k].b);
        end

        // Backpressure: response held while another requester waits
        rsp_ready = 1'b0;
        m_lat = 3; m_c = 32'h7F800000; m_f = 4'b0001;
        push_exp(1, 32'h7F800000, 5'b00001, 4);
        issue(1, 32'h3F800000, 32'h00000000);
        for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
        tick();
        push_exp(3, 32'h7F800000, 5'b00001, 4);
        req_valid[3] = 1'b1;
        req_a[3*W +: W] = 32'h40800000;
        req_b[3*W +: W] = 32'h00000000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_c", rsp_c, 32'h7F800000);
            chk("hold_flags", 32'(rsp_flags), 32'h01);
            chk("hold_no_grant", 32'(req_ready), 0);
        end
        tick();
        rsp_ready = 1'b1;
        issue(3, 32'h40800000, 32'h00000000);
        wait_drain(100);

        // Round robin with all ports requesting from reset
        reset_dut();
        m_lat = 2; m_c = 32'h3F800000; m_f = 4'b0000;
        glog.delete();
        push_exp(0, 32'h3F800000, 5'b0, 3);
        push_exp(1, 32'h3F800000, 5'b0, 3);
        push_exp(2, 32'h3F800000, 5'b0, 3);
        push_exp(3, 32'h3F800000, 5'b0, 3);
        push_exp(0, 32'h3F800000, 5'b0, 3);
        req_valid = '1;
        for (int i = 0; i < 200 && glog.size() < 5; i++) @(negedge clk);
        tick();
        req_valid = '0;
        wait_drain(100);
        chk("rr_grants", 32'(glog.size()), 5);
        if (glog.size() == 5)
            for (int i = 0; i < 5; i++) chk("rr_order", 32'(glog[i]), 32'(i % N));

        // Reset mid-WAIT, then a late divider valid
        reset_dut();
        m_lat = 0;
        issue(2, 32'h40C00000, 32'h40000000);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        man_v = 1'b1;
        tick();
        man_v = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_rsp_after_rst", 32'(rsp_valid), 0);
        end
        tick();
        m_lat = 2; m_c = 32'h40A00000; m_f = 4'b0000;
        glog.delete();
        push_exp(1, 32'h40A00000, 5'b0, 3);
        push_exp(3, 32'h40A00000, 5'b0, 3);
        va = 32'h41200000; vb = 32'h40000000;
        req_valid[3] = 1'b1;
        req_a[3*W +: W] = va;
        req_b[3*W +: W] = vb;
        issue(1, va, vb);
        issue(3, va, vb);
        wait_drain(100);
        chk("post_rst_grant_n", 32'(glog.size()), 2);
        if (glog.size() >= 1) chk("post_rst_first", 32'(glog[0]), 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/fpdiv_arbiter.md
# fpdiv_arbiter

Round-robin arbiter and sequencer that shares one single-precision floating-point divider among NREQ requesters. It accepts operand pairs over valid/ready handshakes and issues one division at a time with a one-cycle start pulse. It returns the quotient, exception flags and requester ID over a single response channel. It sits between the requesting datapaths and the divider; the divider itself is external.

## Interface
- WIDTH, 32: operand/result width (IEEE 754 single).
- NREQ, 4: number of requesters (2..8).
- TMO_CYC, 64: cycles allowed between start pulse and divider valid before timeout.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*WIDTH  dividends, requester i at [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  divisors, same packing.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  $clog2(NREQ)  index of the requester that owns the response.
- rsp_c  out  WIDTH  quotient.
- rsp_flags  out  5  {tmo, unf, ovf, zbz, dbz}.
- div_start  out  1  one-cycle start pulse to divider.
- div_a, div_b  out  WIDTH  registered operands, stable from ISSUE through WAIT.
- div_busy, div_valid  in  1  divider status.
- div_c  in  WIDTH  divider result.
- div_dbz, div_zbz, div_ovf, div_unf  in  1  divider flags.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, the round-robin grant picks the first requesting index at or after ptr, wrapping modulo NREQ. Assert req_ready[g] combinationally in that cycle only; capture req_a/req_b[g] into div_a/div_b and g into the ID register; set ptr = (g+1) mod NREQ; go to ISSUE. With no request, stay in IDLE and leave ptr unchanged.
- ISSUE: div_start=1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT: the counter increments each cycle. Accept the result when div_valid=1 and div_busy=0. The first WAIT cycle is never accepted because the divider's busy flag rises the cycle after start. On accept, register div_c and the flags with tmo=0, then go to RESP. If the counter reaches TMO_CYC-1 without accept, load rsp_c=0 and rsp_flags=5'b10000, then go to RESP.
- RESP: rsp_valid=1, with rsp_id/rsp_c/rsp_flags held stable until rsp_ready=1. On handshake, go to IDLE.
- req_ready is 0 in every state other than IDLE.
- Simultaneous div_valid and timeout in the same cycle: the result wins, tmo=0.
- rst_n low at any time, including mid-WAIT: return to IDLE immediately. Any in-flight operation is dropped, and any late div_valid after reset is ignored because the FSM is in IDLE.

## Timing
- Reset values: state=IDLE, ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_c=0, rsp_flags=0, div_start=0, div_a=0, div_b=0.
- Grant at edge T. div_start is high in cycle T+1. With divider latency L cycles from start to valid, rsp_valid rises L+1 cycles after the start cycle.
- Minimum issue interval: one new grant per response handshake, plus one IDLE cycle.
- All outputs are registered except req_ready, which is decoded from state, req_valid and ptr.

## Structure
- Package fpdiv_pkg holds:
  - the state enum;
  - a packed struct fpdiv_flags_t {tmo, unf, ovf, zbz, dbz};
  - localparam FLAG_W=5;
  - the TMO flag constant.
- Sub-module rr_arb(NREQ): inputs req and ptr, output one-hot grant plus encoded index; purely combinational. Ptr storage stays in fpdiv_arbiter.

## Test plan
- Single request from port 2: a=0x40C00000 (6.0), b=0x40000000 (2.0), divider model returns 0x40400000. Expect rsp_id=2, rsp_c=0x40400000, rsp_flags=0, and div_start high exactly one cycle.
- All four ports requesting continuously from reset, rsp_ready=1. Expect grant order 0,1,2,3,0, with each req_ready a single cycle and never two bits set.
- Port 1: a=0x3F800000, b=0 with model dbz=1. Expect rsp_flags=5'b00001. Hold rsp_ready=0 for 5 cycles: rsp_valid and rsp_c stay stable and no new grant occurs.
- Model never asserts div_valid. Expect rsp_valid exactly TMO_CYC cycles after the start cycle, rsp_flags=5'b10000, rsp_c=0.
- Model asserts div_valid in the same cycle the counter hits TMO_CYC-1. Expect the real result with tmo=0.
- Assert rst_n low for 1 cycle mid-WAIT, then pulse div_valid. Expect no rsp_valid, ptr=0, and the next request granted normally.
